// File: rtl/acorn128_pkg.sv
// +--------------------------------------------------------------------------+
// | acorn128_pkg : shared phase encoding, step budgets and msel codes        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package acorn128_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INIT  = 3'd1,
    PH_AD    = 3'd2,
    PH_MSG   = 3'd3,
    PH_FINAL = 3'd4,
    PH_DONE  = 3'd5
  } phase_e;

  localparam int INIT_STEPS  = 1792;
  localparam int PAD_STEPS   = 256;
  localparam int CA_TAIL     = 128;
  localparam int FINAL_STEPS = 768;
  localparam int TAG_BITS    = 128;
  localparam int TAG_START   = 640;

  localparam logic [1:0] MSEL_KEY  = 2'd0;
  localparam logic [1:0] MSEL_DATA = 2'd1;
  localparam logic [1:0] MSEL_PAD  = 2'd2;
  localparam logic [1:0] MSEL_ZERO = 2'd3;

endpackage

`default_nettype wire

// File: rtl/acorn128_len_counter.sv
// +--------------------------------------------------------------------------+
// | acorn128_len_counter : per-phase step counter with end-of-phase compare  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module acorn128_len_counter #(
  parameter int W     = 8,
  parameter int LEN_W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [LEN_W:0] limit_i,
  output logic [LEN_W:0] count_o,
  output logic           at_end_o
);

  localparam int CW = LEN_W + 1;

  logic [LEN_W:0] count_q;
  logic [LEN_W:0] count_d;

  // Clear wins over advance so the last step of a phase lands on zero.
  assign count_d  = clr_i ? '0 : (en_i ? count_q + CW'(W) : count_q);
  assign at_end_o = (count_q + CW'(W)) >= limit_i;
  assign count_o  = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/acorn128_sequencer.sv
// +--------------------------------------------------------------------------+
// | acorn128_sequencer : length-driven phase/control sequencer for ACORN-128 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module acorn128_sequencer
  import acorn128_pkg::*;
#(
  parameter int W     = 8,
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             decrypt_i,
  input  logic [LEN_W-1:0] ad_len_i,
  input  logic [LEN_W-1:0] msg_len_i,
  input  logic [127:0]     tag_i,
  input  logic             data_vld_i,
  input  logic [W-1:0]     ks_i,
  output logic             data_rdy_o,
  output logic             step_en_o,
  output logic [2:0]       phase_o,
  output logic [1:0]       msel_o,
  output logic             pad_one_o,
  output logic             ca_o,
  output logic             cb_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [127:0]     tag_o,
  output logic             tag_ok_o
);

  localparam int CW = LEN_W + 1;

  phase_e           state_q, state_d;
  logic             decrypt_q;
  logic [LEN_W-1:0] ad_len_q, msg_len_q;
  logic [127:0]     tag_exp_q, tag_q, tag_shift;
  logic             tag_ok_q, err_q;

  logic [LEN_W:0]   step_q, limit, cur_len;
  logic             at_end, len_bad, accept, fin_last, tag_cap;

  assign len_bad = ((ad_len_i % LEN_W'(W)) != '0) || ((msg_len_i % LEN_W'(W)) != '0);
  assign accept  = (state_q == PH_IDLE) && start_i && !len_bad;
  assign cur_len = {1'b0, (state_q == PH_AD) ? ad_len_q : msg_len_q};

  always_comb begin
    limit = '0;
    case (state_q)
      PH_INIT:       limit = CW'(INIT_STEPS);
      PH_AD, PH_MSG: limit = cur_len + CW'(PAD_STEPS);
      PH_FINAL:      limit = CW'(FINAL_STEPS);
      default:       limit = '0;
    endcase
  end

  acorn128_len_counter #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_step_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_d != state_q),
    .en_i     (step_en_o),
    .limit_i  (limit),
    .count_o  (step_q),
    .at_end_o (at_end)
  );

  always_comb begin
    state_d    = state_q;
    step_en_o  = 1'b0;
    data_rdy_o = 1'b0;
    msel_o     = MSEL_KEY;
    pad_one_o  = 1'b0;
    ca_o       = 1'b0;
    cb_o       = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (accept) state_d = PH_INIT;
      end
      PH_INIT: begin
        step_en_o = 1'b1;
        ca_o      = 1'b1;
        cb_o      = 1'b1;
        if (at_end) state_d = PH_AD;
      end
      PH_AD, PH_MSG: begin
        cb_o = (state_q == PH_AD);
        ca_o = step_q < (cur_len + CW'(CA_TAIL));
        if (step_q < cur_len) begin
          msel_o     = MSEL_DATA;
          data_rdy_o = data_vld_i;
          step_en_o  = data_vld_i;
        end else begin
          msel_o    = MSEL_PAD;
          step_en_o = 1'b1;
          pad_one_o = (step_q == cur_len);
        end
        if (step_en_o && at_end) state_d = (state_q == PH_AD) ? PH_MSG : PH_FINAL;
      end
      PH_FINAL: begin
        msel_o    = MSEL_ZERO;
        step_en_o = 1'b1;
        ca_o      = 1'b1;
        cb_o      = 1'b1;
        if (at_end) state_d = PH_DONE;
      end
      PH_DONE: state_d = PH_IDLE;
      default: state_d = PH_IDLE;
    endcase
  end

  // Keystream enters at the top so the earliest tag step ends up in bit 0.
  generate
    if (W == TAG_BITS) begin : g_tag_full
      assign tag_shift = ks_i;
    end else begin : g_tag_shift
      assign tag_shift = {ks_i, tag_q[TAG_BITS-1:W]};
    end
  endgenerate

  assign tag_cap  = (state_q == PH_FINAL) && (step_q >= CW'(TAG_START));
  assign fin_last = (state_q == PH_FINAL) && at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PH_IDLE;
      decrypt_q <= 1'b0;
      ad_len_q  <= '0;
      msg_len_q <= '0;
      tag_exp_q <= '0;
      tag_q     <= '0;
      tag_ok_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == PH_IDLE) && start_i && len_bad;
      if (accept) begin
        decrypt_q <= decrypt_i;
        ad_len_q  <= ad_len_i;
        msg_len_q <= msg_len_i;
        tag_exp_q <= tag_i;
        tag_q     <= '0;
        tag_ok_q  <= 1'b0;
      end else if (tag_cap) begin
        tag_q <= tag_shift;
        if (fin_last) tag_ok_q <= decrypt_q && (tag_shift == tag_exp_q);
      end
    end
  end

  assign phase_o  = state_q;
  assign busy_o   = (state_q != PH_IDLE) && (state_q != PH_DONE);
  assign done_o   = (state_q == PH_DONE);
  assign err_o    = err_q;
  assign tag_o    = tag_q;
  assign tag_ok_o = tag_ok_q;

endmodule

`default_nettype wire
